// File: rtl/tone_sequencer.sv
// tone_sequencer: request-driven buzzer pattern player with pre-emption and a done/busy handshake
module tone_sequencer #(
  parameter int unsigned CLK_HZ      = 32_000_000,
  parameter int unsigned STEP_CYCLES = CLK_HZ / 8,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic [2:0] pattern,
  input  logic       hold,
  output logic       buzz,
  output logic       busy,
  output logic       done,
  output logic [3:0] note
);
  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  state_t           state;
  logic [2:0]       pat;
  logic [1:0]       step, last, nxt;
  logic [CNT_W-1:0] tone_cnt, step_cnt;
  logic             accept, looping, tone_wrap;
  function automatic logic [3:0] rom(input logic [2:0] p, input logic [1:0] s);
    case (p)
      3'd0:    rom = 4'd1;
      3'd1:    rom = s == 2'd0 ? 4'd2 : s == 2'd1 ? 4'd4 : 4'd8;
      3'd2:    rom = s == 2'd0 ? 4'd7 : s == 2'd1 ? 4'd6 : 4'd4;
      3'd3:    rom = s == 2'd0 ? 4'd5 : s == 2'd2 ? 4'd3 : 4'd4;
      default: rom = s[1] ? 4'd10 : 4'd9;
    endcase
  endfunction
  function automatic logic [CNT_W-1:0] half_of(input logic [3:0] n);
    case (n)
      4'd1:    half_of = CNT_W'(CLK_HZ / 1046);
      4'd2:    half_of = CNT_W'(CLK_HZ / 1318);
      4'd3:    half_of = CNT_W'(CLK_HZ / 1480);
      4'd4:    half_of = CNT_W'(CLK_HZ / 1568);
      4'd5:    half_of = CNT_W'(CLK_HZ / 1662);
      4'd6:    half_of = CNT_W'(CLK_HZ / 1864);
      4'd7:    half_of = CNT_W'(CLK_HZ / 1976);
      4'd8:    half_of = CNT_W'(CLK_HZ / 2092);
      4'd9:    half_of = CNT_W'(CLK_HZ / 2636);
      4'd10:   half_of = CNT_W'(CLK_HZ / 3136);
      default: half_of = '0;
    endcase
  endfunction
  assign accept    = play && pattern <= 3'd4 && (pattern < 3'd3 || hold) && (state == IDLE || pattern != 3'd0);
  assign looping   = state != IDLE && pat >= 3'd3;
  assign tone_wrap = tone_cnt == half_of(note) - CNT_W'(1);
  assign last      = pat == 3'd0 ? 2'd0 : pat <= 3'd2 ? 2'd2 : 2'd3;
  assign nxt       = step == last ? 2'd0 : step + 2'd1;
  // Sequencer: request acceptance has priority over loop termination, which has priority over step timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pat      <= '0;
      step     <= '0;
      tone_cnt <= '0;
      step_cnt <= '0;
      buzz     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      note     <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state    <= TONE;
        pat      <= pattern;
        step     <= '0;
        tone_cnt <= '0;
        step_cnt <= '0;
        buzz     <= 1'b0;
        busy     <= 1'b1;
        note     <= rom(pattern, 2'd0);
      end else if (looping && !hold) begin
        state    <= IDLE;
        tone_cnt <= '0;
        step_cnt <= '0;
        buzz     <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
        note     <= '0;
      end else if (state == TONE && step_cnt != STEP_LAST) begin
        step_cnt <= step_cnt + CNT_W'(1);
        tone_cnt <= tone_wrap ? '0 : tone_cnt + CNT_W'(1);
        buzz     <= buzz ^ tone_wrap;
      end else if (state == TONE && GAP_CYCLES != 0) begin
        state    <= GAP;
        tone_cnt <= '0;
        step_cnt <= '0;
        buzz     <= 1'b0;
        note     <= '0;
      end else if (state == GAP && step_cnt != GAP_LAST) begin
        step_cnt <= step_cnt + CNT_W'(1);
      end else if (state != IDLE) begin
        tone_cnt <= '0;
        step_cnt <= '0;
        buzz     <= 1'b0;
        if (step == last && pat < 3'd3) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          note  <= '0;
        end else begin
          state <= TONE;
          step  <= nxt;
          note  <= rom(pat, nxt);
        end
      end
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: legato and gapped instances checked against an elapsed-time model of the patterns
module tb_tone_sequencer;
  localparam int CLK = 100_000, S = 300, G = 40;
  logic clk = 1'b0, reset = 1'b1, play = 1'b0, hold = 1'b0;
  logic [2:0] pattern = 3'd0;
  logic buzz0, busy0, done0, buzz1, busy1, done1;
  logic [3:0] note0, note1;
  logic [6:0] o0, o1, e0, e1;
  int checks = 0, fails = 0;
  int hz [11] = '{0, 523, 659, 740, 784, 831, 932, 988, 1046, 1318, 1568};
  int rom [5][4] = '{'{1, 1, 1, 1}, '{2, 4, 8, 8}, '{7, 6, 4, 4}, '{5, 4, 3, 4}, '{9, 9, 10, 10}};
  int len [5] = '{1, 3, 3, 4, 4};
  int gp [2] = '{0, G};
  bit m_act [2], m_done [2];
  int m_pat [2], m_t [2];

  always #5 clk = ~clk;

  tone_sequencer #(.CLK_HZ(CLK), .STEP_CYCLES(S), .GAP_CYCLES(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .play(play), .pattern(pattern), .hold(hold),
    .buzz(buzz0), .busy(busy0), .done(done0), .note(note0));
  tone_sequencer #(.CLK_HZ(CLK), .STEP_CYCLES(S), .GAP_CYCLES(G), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .play(play), .pattern(pattern), .hold(hold),
    .buzz(buzz1), .busy(busy1), .done(done1), .note(note1));

  assign o0 = {busy0, done0, note0, buzz0};
  assign o1 = {busy1, done1, note1, buzz1};

  function automatic int half(int n);
    return CLK / (2 * hz[n]);
  endfunction

  // Expected {busy, done, note, buzz} from time elapsed since the request was accepted
  function automatic logic [6:0] expv(bit a, int p, int t, bit d, int g);
    int w, n;
    logic b;
    if (!a) return {1'b0, d, 5'b0};
    w = t % (S + g);
    if (w >= S) return {1'b1, d, 5'b0};
    n = rom[p][(t / (S + g)) % len[p]];
    b = ((w / half(n)) % 2) == 1;
    return {1'b1, d, n[3:0], b};
  endfunction

  // Reference: who is playing what, and for how long
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0; m_done[i] <= 1'b0; m_pat[i] <= 0; m_t[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        if (play && pattern <= 4 && !(pattern >= 3 && !hold) && !(m_act[i] && pattern == 0)) begin
          m_act[i] <= 1'b1; m_pat[i] <= int'(pattern); m_t[i] <= 0;
        end else if (m_act[i] && m_pat[i] >= 3 && !hold) begin
          m_act[i] <= 1'b0; m_done[i] <= 1'b1;
        end else if (m_act[i] && m_pat[i] < 3 && m_t[i] + 1 == len[m_pat[i]] * (S + gp[i])) begin
          m_act[i] <= 1'b0; m_done[i] <= 1'b1;
        end else if (m_act[i]) begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  assign e0 = expv(m_act[0], m_pat[0], m_t[0], m_done[0], 0);
  assign e1 = expv(m_act[1], m_pat[1], m_t[1], m_done[1], G);

  task automatic test_reset();
    @(negedge clk);
    checks += 2;
    if (o0 !== 7'b0) begin fails++; $display("FAIL reset_state legato got=%b exp=0000000", o0); end
    if (o1 !== 7'b0) begin fails++; $display("FAIL reset_state gap got=%b exp=0000000", o1); end
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (o0 !== e0) begin fails++; $display("FAIL reset_idle legato got=%b exp=%b", o0, e0); end
    if (o1 !== e1) begin fails++; $display("FAIL reset_idle gap got=%b exp=%b", o1, e1); end
  endtask

  task automatic test_key();
    int nb = 0, nd = 0, rise = -1;
    play = 1'b1; pattern = 3'd0; hold = 1'b0;
    for (int c = 0; c < 360; c++) begin
      @(negedge clk); play = 1'b0;
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL key legato t=%0t got=%b exp=%b", $time, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL key gap t=%0t got=%b exp=%b", $time, o1, e1); end
      nb += int'(busy0); nd += int'(done0);
      if (buzz0 && rise < 0) rise = c;
    end
    checks += 3;
    if (nb != S) begin fails++; $display("FAIL key_busy_len got=%0d exp=%0d", nb, S); end
    if (nd != 1) begin fails++; $display("FAIL key_done_count got=%0d exp=1", nd); end
    if (rise != 95) begin fails++; $display("FAIL key_first_rise got=%0d exp=95", rise); end
  endtask

  task automatic test_open();
    int nb0 = 0, nb1 = 0, nd1 = 0, ng1 = 0;
    play = 1'b1; pattern = 3'd1;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk); play = 1'b0;
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL open legato t=%0t got=%b exp=%b", $time, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL open gap t=%0t got=%b exp=%b", $time, o1, e1); end
      nb0 += int'(busy0); nb1 += int'(busy1); nd1 += int'(done1);
      if (busy1 && note1 == 4'd0) ng1++;
    end
    checks += 4;
    if (nb0 != 3 * S) begin fails++; $display("FAIL open_busy_legato got=%0d exp=%0d", nb0, 3 * S); end
    if (nb1 != 3 * (S + G)) begin fails++; $display("FAIL open_busy_gap got=%0d exp=%0d", nb1, 3 * (S + G)); end
    if (nd1 != 1) begin fails++; $display("FAIL open_done_count got=%0d exp=1", nd1); end
    if (ng1 != 3 * G) begin fails++; $display("FAIL open_gap_cycles got=%0d exp=%0d", ng1, 3 * G); end
  endtask

  task automatic test_alarm();
    play = 1'b1; pattern = 3'd4; hold = 1'b1;
    for (int c = 0; c < 3500; c++) begin
      @(negedge clk); play = 1'b0;
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL alarm legato t=%0t got=%b exp=%b", $time, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL alarm gap t=%0t got=%b exp=%b", $time, o1, e1); end
    end
    hold = 1'b0;
    @(negedge clk);
    checks += 2;
    if ({busy0, buzz0, done0} !== 3'b001) begin fails++; $display("FAIL alarm_stop legato got=%b exp=001", {busy0, buzz0, done0}); end
    if ({busy1, buzz1, done1} !== 3'b001) begin fails++; $display("FAIL alarm_stop gap got=%b exp=001", {busy1, buzz1, done1}); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL alarm_after legato got=%b exp=%b", o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL alarm_after gap got=%b exp=%b", o1, e1); end
    end
  endtask

  task automatic test_preempt();
    int nd0 = 0, nd1 = 0;
    play = 1'b1; pattern = 3'd2; hold = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); play = 1'b0;
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL err legato t=%0t got=%b exp=%b", $time, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL err gap t=%0t got=%b exp=%b", $time, o1, e1); end
    end
    play = 1'b1; pattern = 3'd1;
    @(negedge clk); play = 1'b0;
    checks += 2;
    if ({note0, done0, buzz0} !== 6'b0010_0_0) begin fails++; $display("FAIL preempt_start legato got=%b exp=001000", {note0, done0, buzz0}); end
    if ({note1, done1, buzz1} !== 6'b0010_0_0) begin fails++; $display("FAIL preempt_start gap got=%b exp=001000", {note1, done1, buzz1}); end
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      play = (c == 300); pattern = 3'd0;
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL preempt legato t=%0t got=%b exp=%b", $time, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL preempt gap t=%0t got=%b exp=%b", $time, o1, e1); end
      nd0 += int'(done0); nd1 += int'(done1);
    end
    play = 1'b0;
    checks += 2;
    if (nd0 != 1) begin fails++; $display("FAIL preempt_done legato got=%0d exp=1", nd0); end
    if (nd1 != 1) begin fails++; $display("FAIL preempt_done gap got=%0d exp=1", nd1); end
  endtask

  task automatic test_ignored();
    play = 1'b1; pattern = 3'd6; hold = 1'b0;
    @(negedge clk);
    checks += 2;
    if (o0 !== 7'b0) begin fails++; $display("FAIL ignore_invalid legato got=%b exp=0000000", o0); end
    if (o1 !== 7'b0) begin fails++; $display("FAIL ignore_invalid gap got=%b exp=0000000", o1); end
    pattern = 3'd3;
    @(negedge clk); play = 1'b0;
    checks += 2;
    if (o0 !== 7'b0) begin fails++; $display("FAIL ignore_lock legato got=%b exp=0000000", o0); end
    if (o1 !== 7'b0) begin fails++; $display("FAIL ignore_lock gap got=%b exp=0000000", o1); end
  endtask

  task automatic test_reset_mid();
    int nb = 0, nd = 0;
    play = 1'b1; pattern = 3'd3; hold = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); play = 1'b0;
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL lock legato t=%0t got=%b exp=%b", $time, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL lock gap t=%0t got=%b exp=%b", $time, o1, e1); end
    end
    #2 reset = 1'b1;
    #1;
    checks += 2;
    if (o0 !== 7'b0) begin fails++; $display("FAIL async_reset legato got=%b exp=0000000", o0); end
    if (o1 !== 7'b0) begin fails++; $display("FAIL async_reset gap got=%b exp=0000000", o1); end
    @(negedge clk); reset = 1'b0; hold = 1'b0;
    play = 1'b1; pattern = 3'd0;
    for (int c = 0; c < 360; c++) begin
      @(negedge clk); play = 1'b0;
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL key_after_reset legato t=%0t got=%b exp=%b", $time, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL key_after_reset gap t=%0t got=%b exp=%b", $time, o1, e1); end
      nb += int'(busy0); nd += int'(done0);
    end
    checks += 2;
    if (nb != S) begin fails++; $display("FAIL key_after_reset_busy got=%0d exp=%0d", nb, S); end
    if (nd != 1) begin fails++; $display("FAIL key_after_reset_done got=%0d exp=1", nd); end
  endtask

  task automatic test_random();
    hold = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL random legato t=%0t got=%b exp=%b", $time, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL random gap t=%0t got=%b exp=%b", $time, o1, e1); end
      play = $urandom_range(0, 29) == 0;
      pattern = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) hold = ~hold;
    end
    play = 1'b0;
  endtask

  initial begin
    test_reset();
    test_key();
    test_open();
    test_alarm();
    test_preempt();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Parametrised buzzer pattern player for the door-lock front end. It receives one-shot requests (key click, open, error) and looped requests (lockout, alarm) from the lock controller. It plays each request as a sequence of square-wave notes on a single buzzer pin. Unlike the previous fixed-rate generator, it has:
- clock-frequency-derived note dividers;
- configurable step length and inter-note gap;
- a done/busy handshake;
- defined pre-emption rules.

## Interface
- CLK_HZ, 32_000_000, input clock frequency; note half-period HALF(n) = CLK_HZ/(2·f_n), integer division at elaboration.
- STEP_CYCLES, CLK_HZ/8, cycles a note sounds per step (≥1).
- GAP_CYCLES, 0, silent cycles after each note step (0 = legato, GAP state skipped).
- CNT_W, 32, width of the tone and step counters; must hold max(STEP_CYCLES, GAP_CYCLES, HALF).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- play  in  1  request strobe, sampled every clk.
- pattern  in  3  pattern select, valid with play: 0 KEY, 1 OPEN, 2 ERR, 3 LOCK, 4 ALARM, 5–7 invalid.
- hold  in  1  keeps looped patterns (LOCK, ALARM) running while high.
- buzz  out  1  square-wave drive to the buzzer.
- busy  out  1  high while a pattern is playing.
- done  out  1  one-cycle pulse when playback ends normally (not on pre-emption or reset).
- note  out  4  note code currently sounding; 0 = silent.

## Operation
- Note codes and frequencies (Hz):

  | Code | Note | Hz | Code | Note | Hz |
  |---|---|---|---|---|---|
  | 1 | C5 | 523 | 6 | A#5 | 932 |
  | 2 | E5 | 659 | 7 | B5 | 988 |
  | 3 | F#5 | 740 | 8 | C6 | 1046 |
  | 4 | G5 | 784 | 9 | E6 | 1318 |
  | 5 | G#5 | 831 | 10 | G6 | 1568 |

- Pattern ROM:
  - KEY = 1, one-shot, 1 step.
  - OPEN = 2,4,8, one-shot.
  - ERR = 7,6,4, one-shot.
  - LOCK = 5,4,3,4, looping.
  - ALARM = 9,9,10,10, looping.
- FSM states:
  - IDLE: busy=0, note=0, buzz=0.
  - TONE: note=ROM[step]; the tone counter runs and buzz toggles when the counter reaches HALF−1, then the counter clears.
  - GAP: note=0, buzz=0, tone counter held at 0.
- Acceptance rules:
  - play with pattern 5–7 is ignored.
  - play with LOCK/ALARM while hold=0 is ignored.
  - In IDLE, any other valid play is accepted.
  - While busy, a valid play is accepted (pre-empts and restarts from step 0) unless pattern=KEY; KEY while busy is dropped.
  - A play for the pattern already looping is also accepted (restart).
- Step sequencing:
  - TONE lasts STEP_CYCLES cycles, then GAP for GAP_CYCLES cycles (skipped if 0), then the next step.
  - After the last step of a one-shot: IDLE plus a done pulse.
  - After the last step of a loop: step 0.
- Loop termination: while playing LOCK/ALARM, hold=0 on any cycle → IDLE on the next edge, done pulse, no step completion.
- Every new step, and every accepted play, clears the tone counter and forces buzz=0.

## Timing
- Reset values: buzz=0, busy=0, done=0, note=0, FSM=IDLE, all counters 0.
- Play latency:
  - play accepted at edge t → busy=1 and note=first code from edge t+1 (registered outputs).
  - First buzz rise at edge t+1+HALF.
- Step timing:
  - Each step occupies exactly STEP_CYCLES+GAP_CYCLES cycles.
  - A one-shot of N steps keeps busy high for N·(STEP_CYCLES+GAP_CYCLES) cycles.
  - done asserts on the cycle busy falls.
- Simultaneous events:
  - play accepted on the same edge a pattern would end → new pattern starts, no done.
  - hold falling on the same edge as an accepted play → the play rule applies to the new request, and the old loop ends with no done.
- Reset mid-pattern: outputs drop to reset values asynchronously; the next play is treated as from IDLE.
- Counters saturate nowhere; they wrap only via explicit clears, and all comparisons are at CNT_W width.

## Test plan
- **KEY click.** CLK_HZ=1_000_000, STEP_CYCLES=4000, GAP_CYCLES=0; play KEY.
  - note=1 and busy=1 for 4000 cycles.
  - buzz period 1912 cycles (HALF=956).
  - done pulse at cycle 4001, then note=0, buzz=0.
- **OPEN with gaps.** GAP_CYCLES=500; play OPEN.
  - Notes 2, 0, 4, 0, 8, 0 with durations 4000, 500 repeated.
  - HALF = 758, 637, 478.
  - busy high 13500 cycles, single done.
- **ALARM loop.** play ALARM with hold=1 for 40000 cycles.
  - Note sequence 9,9,10,10 repeats 2.5 times.
  - hold→0 mid-step: next cycle busy=0, buzz=0, done=1.
- **Pre-emption.**
  - play ERR; at cycle 2000, play OPEN → note=2 next cycle, step restarts, no done for ERR.
  - play KEY during OPEN → ignored, OPEN completes normally.
- **Invalid and ignored requests.** play pattern=6, and play LOCK with hold=0 → busy stays 0, no outputs change.
- **Reset mid-pattern.** Reset pulse asserted asynchronously mid-LOCK.
  - Outputs go to 0 before the next clk edge.
  - After release, play KEY behaves exactly as in the KEY click scenario.
